// File: rtl/multi_edge_debouncer.sv
// Multi-channel front-panel input conditioner: sync, debounce, edge detect,
// hold-to-repeat and lowest-index event report.
module multi_edge_debouncer #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 8,
    localparam int EW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    input  logic [1:0]      edge_sel,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_tick,
    output logic [N_CH-1:0] fall_tick,
    output logic [N_CH-1:0] rpt_tick,
    output logic [N_CH-1:0] pulse,
    output logic            evt_valid,
    output logic [EW-1:0]   evt_ch
);

    localparam int CW   = $clog2((DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES : 2);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                         : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_DELAY  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] H_PERIOD = HW'(REPEAT_PERIOD);
    localparam bit            RPT_EN   = (REPEAT_DELAY > 0);
    localparam bit            DB_ONE   = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } db_state_e;

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_d [SYNC_STAGES];
    logic [N_CH-1:0] s;

    db_state_e       state_q [N_CH];
    db_state_e       state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [N_CH-1:0] level_q, level_d;

    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;

    logic [HW-1:0]   hold_q  [N_CH];
    logic [HW-1:0]   hold_d  [N_CH];
    logic [N_CH-1:0] armed_q, armed_d;
    logic [N_CH-1:0] rpt_q, rpt_d;

    logic sel_rise, sel_fall;

    always_comb begin
        sync_d[0] = raw_in;
        for (int j = 1; j < SYNC_STAGES; j++) begin
            sync_d[j] = sync_q[j-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            level_d[i] = level_q[i];
            unique case (state_q[i])
                STABLE_LO: begin
                    cnt_d[i] = '0;
                    if (s[i]) begin
                        if (DB_ONE) begin
                            state_d[i] = STABLE_HI;
                            level_d[i] = 1'b1;
                        end else begin
                            state_d[i] = PEND_HI;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                end
                PEND_HI: begin
                    if (!s[i]) begin
                        state_d[i] = STABLE_LO;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = STABLE_HI;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                STABLE_HI: begin
                    cnt_d[i] = '0;
                    if (!s[i]) begin
                        if (DB_ONE) begin
                            state_d[i] = STABLE_LO;
                            level_d[i] = 1'b0;
                        end else begin
                            state_d[i] = PEND_LO;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                end
                PEND_LO: begin
                    if (s[i]) begin
                        state_d[i] = STABLE_HI;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = STABLE_LO;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            endcase
        end
    end

    assign rise_d = level_d & ~level_q;
    assign fall_d = ~level_d & level_q;

    // First fire counts up to the delay; afterwards the counter wraps 1..period.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            hold_d[i]  = '0;
            armed_d[i] = 1'b0;
            rpt_d[i]   = 1'b0;
            if (level_d[i] && level_q[i]) begin
                if (armed_q[i] ? (hold_q[i] == H_PERIOD)
                               : (hold_q[i] == H_DELAY)) begin
                    hold_d[i]  = HW'(1);
                    armed_d[i] = 1'b1;
                end else begin
                    hold_d[i]  = hold_q[i] + HW'(1);
                    armed_d[i] = armed_q[i];
                end
            end
            rpt_d[i] = RPT_EN && level_d[i] && level_q[i] &&
                       (armed_d[i] ? (hold_d[i] == H_PERIOD)
                                   : (hold_d[i] == H_DELAY));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= STABLE_LO;
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            armed_q <= '0;
            rpt_q   <= '0;
        end else begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_d[j];
            end
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hold_q[i]  <= hold_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            armed_q <= armed_d;
            rpt_q   <= rpt_d;
        end
    end

    assign level_out = level_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;
    assign rpt_tick  = rpt_q;

    always_comb begin
        sel_rise = 1'b0;
        sel_fall = 1'b0;
        case (edge_sel)
            2'b00:   sel_rise = 1'b1;
            2'b01:   sel_fall = 1'b1;
            2'b10: begin
                sel_rise = 1'b1;
                sel_fall = 1'b1;
            end
            default: ;
        endcase
    end

    assign pulse = (rise_q & {N_CH{sel_rise}}) |
                   (fall_q & {N_CH{sel_fall}}) |
                   rpt_q;

    always_comb begin
        evt_valid = |pulse;
        evt_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pulse[i]) begin
                evt_ch = EW'(i);
            end
        end
    end

endmodule

// File: tb/tb_multi_edge_debouncer.sv
// Randomised and directed checks of multi_edge_debouncer against a
// run-length / elapsed-time reference model.
module tb_multi_edge_debouncer;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] raw_in = '0;
    logic [1:0]   edge_sel = 2'b00;
    logic [N-1:0] level_out, rise_tick, fall_tick, rpt_tick, pulse;
    logic         evt_valid;
    logic [1:0]   evt_ch;

    multi_edge_debouncer #(
        .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .edge_sel(edge_sel),
        .level_out(level_out), .rise_tick(rise_tick),
        .fall_tick(fall_tick), .rpt_tick(rpt_tick), .pulse(pulse),
        .evt_valid(evt_valid), .evt_ch(evt_ch)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0] m_sync [S];
    logic [N-1:0] m_level, m_rise, m_fall, m_rpt;
    int           m_run  [N];
    int           m_hold [N];

    logic [22:0] obs;
    assign obs = {level_out, rise_tick, fall_tick, rpt_tick,
                  pulse, evt_valid, evt_ch};

    task automatic model_reset();
        for (int j = 0; j < S; j++) m_sync[j] = '0;
        m_level = '0; m_rise = '0; m_fall = '0; m_rpt = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_hold[i] = 0;
        end
    endtask

    // Level flips after D consecutive synced samples disagree with it.
    task automatic model_edge(input logic [N-1:0] r);
        logic [N-1:0] s_old;
        s_old = m_sync[S-1];
        for (int j = S - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
        m_sync[0] = r;
        m_rise = '0; m_fall = '0; m_rpt = '0;
        for (int i = 0; i < N; i++) begin
            if (s_old[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_level[i] = ~m_level[i];
                    m_run[i] = 0;
                    if (m_level[i]) m_rise[i] = 1'b1;
                    else m_fall[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
            if (m_level[i]) m_hold[i] = m_rise[i] ? 0 : m_hold[i] + 1;
            else m_hold[i] = 0;
            m_rpt[i] = (RD > 0) && m_level[i] && (m_hold[i] >= RD) &&
                       ((m_hold[i] - RD) % RP == 0);
        end
    endtask

    function automatic logic [22:0] exp_vec();
        logic [N-1:0] p;
        logic sr, sf;
        logic [1:0] c;
        sr = (edge_sel == 2'b00) || (edge_sel == 2'b10);
        sf = (edge_sel == 2'b01) || (edge_sel == 2'b10);
        p = (m_rise & {N{sr}}) | (m_fall & {N{sf}}) | m_rpt;
        c = 2'd0;
        for (int i = N - 1; i >= 0; i--) if (p[i]) c = 2'(i);
        return {m_level, m_rise, m_fall, m_rpt, p, |p, c};
    endfunction

    task automatic step(input logic [N-1:0] r);
        raw_in = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic settle(input logic [N-1:0] r, input int n);
        repeat (n) step(r);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        raw_in = 4'hF;
        edge_sel = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (obs !== 23'd0) begin
            n_errors++;
            $display("FAIL reset_hold: got %h expected 0", obs);
        end
        raw_in = '0;
        edge_sel = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step('0);
        n_checks++;
        if (obs !== exp_vec()) begin
            n_errors++;
            $display("FAIL reset_release: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_latency();
        edge_sel = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            step(4'b0001);
            n_checks++;
            if (level_out[0] !== (k >= 6)) begin
                n_errors++;
                $display("FAIL latency_level k=%0d: got %b expected %b",
                         k, level_out[0], k >= 6);
            end
            n_checks++;
            if (rise_tick[0] !== (k == 6)) begin
                n_errors++;
                $display("FAIL latency_rise k=%0d: got %b expected %b",
                         k, rise_tick[0], k == 6);
            end
            if (k == 6) begin
                n_checks++;
                if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
                    n_errors++;
                    $display("FAIL latency_evt: got %b/%0d expected 1/0",
                             evt_valid, evt_ch);
                end
            end
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL latency_model k=%0d: got %h expected %h",
                         k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_glitch();
        logic [N-1:0] r;
        settle('0, 12);
        for (int k = 1; k <= 15; k++) begin
            r = (k <= 3) ? 4'b0010 : 4'b0000;
            step(r);
            n_checks++;
            if ({level_out[1], rise_tick[1], fall_tick[1]} !== 3'b000) begin
                n_errors++;
                $display("FAIL glitch k=%0d: got %b expected 000", k,
                         {level_out[1], rise_tick[1], fall_tick[1]});
            end
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL glitch_model k=%0d: got %h expected %h",
                         k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_edge_sel();
        logic [1:0] modes [3];
        int want [3];
        int cnt;
        modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11;
        want[0] = 1; want[1] = 2; want[2] = 0;
        for (int m = 0; m < 3; m++) begin
            settle('0, 10);
            edge_sel = modes[m];
            cnt = 0;
            for (int k = 0; k < 16; k++) begin
                step((k < 8) ? 4'b0100 : 4'b0000);
                if (pulse[2]) cnt++;
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_errors++;
                    $display("FAIL edge_sel_model m=%b k=%0d: got %h expected %h",
                             modes[m], k, obs, exp_vec());
                end
                if (m == 0) begin
                    n_checks++;
                    if (pulse[2] !== fall_tick[2]) begin
                        n_errors++;
                        $display("FAIL fall_only k=%0d: got %b expected %b",
                                 k, pulse[2], fall_tick[2]);
                    end
                end
            end
            n_checks++;
            if (cnt != want[m]) begin
                n_errors++;
                $display("FAIL edge_sel_count m=%b: got %0d expected %0d",
                         modes[m], cnt, want[m]);
            end
        end
    endtask

    task automatic test_repeat();
        int exp_k [7] = '{10, 13, 16, 19, 22, 25, 28};
        int seen [$];
        int waited;
        int late;
        int first;
        edge_sel = 2'b11;
        settle('0, 10);
        waited = 0;
        do begin
            step(4'b1000);
            waited++;
        end while (!rise_tick[3] && waited < 20);
        n_checks++;
        if (!rise_tick[3]) begin
            n_errors++;
            $display("FAIL repeat_rise: got 0 expected 1 within 20 cycles");
        end
        for (int k = 1; k <= 30; k++) begin
            step(4'b1000);
            if (rpt_tick[3]) seen.push_back(k);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL repeat_model k=%0d: got %h expected %h",
                         k, obs, exp_vec());
            end
        end
        n_checks++;
        if (seen.size() != 7) begin
            n_errors++;
            $display("FAIL repeat_count: got %0d expected 7", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 7; i++) begin
            n_checks++;
            if (seen[i] != exp_k[i]) begin
                n_errors++;
                $display("FAIL repeat_at[%0d]: got %0d expected %0d",
                         i, seen[i], exp_k[i]);
            end
        end
        late = 0;
        for (int k = 0; k < 20; k++) begin
            step('0);
            if (rpt_tick[3] && !level_out[3]) late++;
        end
        n_checks++;
        if (late != 0 || level_out[3] !== 1'b0) begin
            n_errors++;
            $display("FAIL repeat_release: got %0d/%b expected 0/0",
                     late, level_out[3]);
        end
        waited = 0;
        do begin
            step(4'b1000);
            waited++;
        end while (!rise_tick[3] && waited < 20);
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            step(4'b1000);
            if (rpt_tick[3] && first < 0) first = k;
        end
        n_checks++;
        if (first != RD) begin
            n_errors++;
            $display("FAIL repeat_restart: got %0d expected %0d", first, RD);
        end
    endtask

    task automatic test_simultaneous();
        int waited;
        edge_sel = 2'b00;
        settle('0, 12);
        waited = 0;
        do begin
            step(4'b1010);
            waited++;
        end while (rise_tick == '0 && waited < 20);
        n_checks++;
        if (rise_tick !== 4'b1010 || pulse !== 4'b1010) begin
            n_errors++;
            $display("FAIL simul_pulse: got %b/%b expected 1010/1010",
                     rise_tick, pulse);
        end
        n_checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin
            n_errors++;
            $display("FAIL simul_evt: got %b/%0d expected 1/1",
                     evt_valid, evt_ch);
        end
    endtask

    task automatic test_reset_mid();
        int rise_k;
        edge_sel = 2'b00;
        settle(4'b0100, 12);
        settle(4'b0101, 4);
        n_checks++;
        if (level_out !== 4'b0100) begin
            n_errors++;
            $display("FAIL mid_pre: got %b expected 0100", level_out);
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (obs !== 23'd0) begin
            n_errors++;
            $display("FAIL mid_reset: got %h expected 0", obs);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        rise_k = -1;
        for (int k = 1; k <= 10; k++) begin
            step(4'b0101);
            if (rise_tick[0] && rise_k < 0) rise_k = k;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL mid_model k=%0d: got %h expected %h",
                         k, obs, exp_vec());
            end
        end
        n_checks++;
        if (rise_k != S + D) begin
            n_errors++;
            $display("FAIL mid_latency: got %0d expected %0d", rise_k, S + D);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        r = raw_in;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(9) == 0) r[i] = ~r[i];
            end
            if ($urandom_range(199) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                model_reset();
                n_checks++;
                if (obs !== 23'd0) begin
                    n_errors++;
                    $display("FAIL rand_reset k=%0d: got %h expected 0", k, obs);
                end
                @(posedge clk);
                #2;
                reset = 1'b0;
            end
            step(r);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL rand_model k=%0d: got %h expected %h",
                         k, obs, exp_vec());
            end
            if ($urandom_range(7) == 0) begin
                edge_sel = 2'($urandom_range(3));
                #1;
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_errors++;
                    $display("FAIL rand_sel k=%0d: got %h expected %h",
                             k, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_glitch();
        test_edge_sel();
        test_repeat();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
